// File: rtl/lcd_timing_pkg.sv
// Shared types and constants for the LCD timing and test-pattern generator:
// pattern mode encodings, the RGB565 pixel struct and the colour-bar table.
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRID  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam int unsigned NUM_BARS = 8;

  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_BLACK = 16'h0000;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [NUM_BARS-1:0][15:0] BAR_RGB = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

endpackage

// File: rtl/lcd_pattern_rgb.sv
// Combinational test-pattern colour for one active pixel; the parent registers it.
// Bar boundaries are multiples of H_ACTIVE/8 fixed at elaboration; pixels past 8 bars are black.
module lcd_pattern_rgb
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned CW       = 12
) (
  input  mode_e          mode_q,
  input  logic [CW-1:0]  pix_x,
  input  logic [CW-1:0]  pix_y,
  input  logic [15:0]    solid_rgb,
  input  logic [2:0]     scroll,
  output rgb565_t        rgb_c
);

  localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;

  logic [7:0] px8;
  logic [7:0] py8;
  logic [2:0] bar;
  logic       in_bars;

  always_comb begin
    px8     = 8'(pix_x);
    py8     = 8'(pix_y);
    bar     = 3'd0;
    // Comparator chain against constant boundaries instead of a divider
    for (int unsigned k = 1; k < NUM_BARS; k++) begin
      if (32'(pix_x) >= k * BAR_W) bar = 3'(k);
    end
    in_bars = 32'(pix_x) < NUM_BARS * BAR_W;

    rgb_c = rgb565_t'(RGB_BLACK);
    case (mode_q)
      MODE_BARS: begin
        if (in_bars) rgb_c = rgb565_t'(BAR_RGB[bar + scroll]);
      end
      MODE_GRID: begin
        if (px8[4:0] == 5'd0 || py8[4:0] == 5'd0) rgb_c = rgb565_t'(RGB_WHITE);
      end
      MODE_SOLID: begin
        rgb_c = rgb565_t'(solid_rgb);
      end
      MODE_GRAD: begin
        rgb_c.r = px8[7:3];
        rgb_c.g = py8[7:2];
        rgb_c.b = ~px8[7:3];
      end
    endcase
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised RGB565 LCD raster timing and test-pattern generator; all outputs registered.
// Optional LCD_TIMING_FRAME_CNT_EN adds a 16-bit frame counter port and scrolls the colour bars.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 210,
  parameter int unsigned H_SYNC   = 1,
  parameter int unsigned H_BP     = 182,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 45,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 1,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 12
) (
  input  logic          PixelClk,
  input  logic          nRST,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [15:0]   solid_rgb,
  output logic          LCD_DE,
  output logic          LCD_HSYNC,
  output logic          LCD_VSYNC,
  output logic [4:0]    LCD_R,
  output logic [5:0]    LCD_G,
  output logic [4:0]    LCD_B,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
`ifdef LCD_TIMING_FRAME_CNT_EN
  output logic [15:0]   frame_cnt,
`endif
  output logic          frame_start,
  output logic          line_start
);

  localparam int unsigned H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_ACT_START = H_SYNC + H_BP;
  localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int unsigned V_ACT_START = V_SYNC + V_BP;
  localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          at_origin;
  logic          hs_act_c;
  logic          vs_act_c;
  logic          de_c;
  logic [CW-1:0] px_c;
  logic [CW-1:0] py_c;
  mode_e         mode_q;
  logic [2:0]    scroll;
  rgb565_t       rgb_c;

  // Raster counters; en=0 parks them at the origin
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    h_last    = h_cnt == CW'(H_TOTAL - 1);
    v_last    = v_cnt == CW'(V_TOTAL - 1);
    at_origin = (h_cnt == '0) && (v_cnt == '0);
    hs_act_c  = h_cnt < CW'(H_SYNC);
    vs_act_c  = v_cnt < CW'(V_SYNC);
    de_c      = (h_cnt >= CW'(H_ACT_START)) && (h_cnt < CW'(H_ACT_END)) &&
                (v_cnt >= CW'(V_ACT_START)) && (v_cnt < CW'(V_ACT_END));
    px_c      = de_c ? h_cnt - CW'(H_ACT_START) : '0;
    py_c      = de_c ? v_cnt - CW'(V_ACT_START) : '0;
  end

  // Pattern select only changes at frame start so a frame never mixes patterns
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      mode_q <= MODE_BARS;
    end else if (en && at_origin) begin
      mode_q <= mode_e'(mode);
    end
  end

`ifdef LCD_TIMING_FRAME_CNT_EN
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      frame_cnt <= '0;
    end else if (en && at_origin) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign scroll = frame_cnt[8:6];
`else
  assign scroll = 3'd0;
`endif

  lcd_pattern_rgb #(
    .H_ACTIVE (H_ACTIVE),
    .CW       (CW)
  ) u_pattern (
    .mode_q    (mode_q),
    .pix_x     (px_c),
    .pix_y     (py_c),
    .solid_rgb (solid_rgb),
    .scroll    (scroll),
    .rgb_c     (rgb_c)
  );

  // Output stage: every pin lags the counters by exactly one cycle
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      LCD_DE      <= 1'b0;
      LCD_HSYNC   <= ~HS_POL;
      LCD_VSYNC   <= ~VS_POL;
      LCD_R       <= '0;
      LCD_G       <= '0;
      LCD_B       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (!en) begin
      LCD_DE      <= 1'b0;
      LCD_HSYNC   <= ~HS_POL;
      LCD_VSYNC   <= ~VS_POL;
      LCD_R       <= '0;
      LCD_G       <= '0;
      LCD_B       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      LCD_DE      <= de_c;
      LCD_HSYNC   <= hs_act_c ? HS_POL : ~HS_POL;
      LCD_VSYNC   <= vs_act_c ? VS_POL : ~VS_POL;
      LCD_R       <= de_c ? rgb_c.r : 5'd0;
      LCD_G       <= de_c ? rgb_c.g : 6'd0;
      LCD_B       <= de_c ? rgb_c.b : 5'd0;
      pix_x       <= px_c;
      pix_y       <= py_c;
      frame_start <= at_origin;
      line_start  <= h_cnt == '0;
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen: random stimulus against a raster-position model,
// plus directed frame statistics, mode latching, enable drop and asynchronous reset.
module tb_lcd_timing_gen;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HS  = 2;
  localparam int HBP = 3;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VS  = 1;
  localparam int VBP = 1;
  localparam int CW  = 12;
  localparam int HT  = HS + HBP + HA + HFP;
  localparam int VT  = VS + VBP + VA + VFP;
  localparam int FT  = HT * VT;

  logic          PixelClk = 1'b0;
  logic          nRST;
  logic          en;
  logic [1:0]    mode;
  logic [15:0]   solid_rgb;

  logic          de_a, hs_a, vs_a, fs_a, ls_a;
  logic [4:0]    r_a, b_a;
  logic [5:0]    g_a;
  logic [CW-1:0] px_a, py_a;
  logic          de_b, hs_b, vs_b, fs_b, ls_b;
  logic [4:0]    r_b, b_b;
  logic [5:0]    g_b;
  logic [CW-1:0] px_b, py_b;
`ifdef LCD_TIMING_FRAME_CNT_EN
  logic [15:0]   fc_a, fc_b;
`endif

  always #5 PixelClk = ~PixelClk;

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
  ) u_dut (
    .PixelClk(PixelClk), .nRST(nRST), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .LCD_DE(de_a), .LCD_HSYNC(hs_a), .LCD_VSYNC(vs_a),
    .LCD_R(r_a), .LCD_G(g_a), .LCD_B(b_a), .pix_x(px_a), .pix_y(py_a),
`ifdef LCD_TIMING_FRAME_CNT_EN
    .frame_cnt(fc_a),
`endif
    .frame_start(fs_a), .line_start(ls_a)
  );

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
  ) u_dut_pol (
    .PixelClk(PixelClk), .nRST(nRST), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .LCD_DE(de_b), .LCD_HSYNC(hs_b), .LCD_VSYNC(vs_b),
    .LCD_R(r_b), .LCD_G(g_b), .LCD_B(b_b), .pix_x(px_b), .pix_y(py_b),
`ifdef LCD_TIMING_FRAME_CNT_EN
    .frame_cnt(fc_b),
`endif
    .frame_start(fs_b), .line_start(ls_b)
  );

  int n_checks;
  int n_errors;

  // Model state: pos is the number of counted cycles since the raster was last parked
  int          pos;
  int          mq;
  int          fcnt;
  bit          e_de, e_hs, e_vs, e_fs, e_ls;
  int          e_x, e_y;
  logic [15:0] e_rgb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bar_colour(input int i);
    case (i)
      0:       return 16'hFFFF;
      1:       return 16'hFFE0;
      2:       return 16'h07FF;
      3:       return 16'h07E0;
      4:       return 16'hF81F;
      5:       return 16'hF800;
      6:       return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] ref_rgb(input int m, input int x, input int y,
                                          input logic [15:0] solid, input int scr);
    int bw, r, g, b;
    bw = HA / 8;
    case (m)
      0: begin
        if (bw == 0 || x >= 8 * bw) return 16'h0000;
        return bar_colour(((x / bw) + scr) % 8);
      end
      1: return ((x % 32) == 0 || (y % 32) == 0) ? 16'hFFFF : 16'h0000;
      2: return solid;
      default: begin
        r = (x / 8) % 32;
        g = (y / 4) % 64;
        b = 31 - r;
        return {5'(r), 6'(g), 5'(b)};
      end
    endcase
  endfunction

  task automatic model_clear_outputs();
    e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_ls = 0;
    e_x = 0; e_y = 0; e_rgb = 16'h0000;
  endtask

  task automatic model_reset();
    pos = 0; mq = 0; fcnt = 0;
    model_clear_outputs();
  endtask

  task automatic model_edge();
    int h, v, scr;
    if (!en) begin
      model_clear_outputs();
      pos = 0;
    end else begin
      h = pos % HT;
      v = pos / HT;
`ifdef LCD_TIMING_FRAME_CNT_EN
      scr = (fcnt / 64) % 8;
`else
      scr = 0;
`endif
      e_hs  = h < HS;
      e_vs  = v < VS;
      e_de  = (h >= HS + HBP) && (h < HS + HBP + HA) && (v >= VS + VBP) && (v < VS + VBP + VA);
      e_x   = e_de ? h - (HS + HBP) : 0;
      e_y   = e_de ? v - (VS + VBP) : 0;
      e_fs  = (h == 0) && (v == 0);
      e_ls  = h == 0;
      e_rgb = e_de ? ref_rgb(mq, e_x, e_y, solid_rgb, scr) : 16'h0000;
      if (e_fs) begin
        mq   = int'(mode);
        fcnt = (fcnt + 1) % 65536;
      end
      pos = (pos + 1) % FT;
    end
  endtask

  task automatic check_outputs();
    check("de",       32'(de_a), 32'(e_de));
    check("hsync",    32'(hs_a), e_hs ? 32'd0 : 32'd1);
    check("vsync",    32'(vs_a), e_vs ? 32'd0 : 32'd1);
    check("rgb",      32'({r_a, g_a, b_a}), 32'(e_rgb));
    check("pix_x",    32'(px_a), 32'(e_x));
    check("pix_y",    32'(py_a), 32'(e_y));
    check("fstart",   32'(fs_a), 32'(e_fs));
    check("lstart",   32'(ls_a), 32'(e_ls));
    check("hsync_p1", 32'(hs_b), e_hs ? 32'd1 : 32'd0);
    check("vsync_p1", 32'(vs_b), e_vs ? 32'd1 : 32'd0);
    check("de_p1",    32'(de_b), 32'(e_de));
    check("rgb_p1",   32'({r_b, g_b, b_b}), 32'(e_rgb));
    check("pix_p1",   32'({px_b, py_b}), 32'({12'(e_x), 12'(e_y)}));
    check("strb_p1",  32'({fs_b, ls_b}), 32'({e_fs, e_ls}));
`ifdef LCD_TIMING_FRAME_CNT_EN
    check("frame_cnt",    32'(fc_a), 32'(fcnt));
    check("frame_cnt_p1", 32'(fc_b), 32'(fcnt));
`endif
  endtask

  task automatic step();
    @(posedge PixelClk);
    if (nRST) model_edge();
    #1;
    check_outputs();
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before the next clock edge
  task automatic do_reset();
    #3 nRST = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (3) step();
    @(negedge PixelClk);
    nRST = 1'b1;
  endtask

  initial begin
    int fs_idx[$];
    int de_cnt, hs_low, vs_low, de_first, guard, solid_cnt, off_de_rgb;
    logic [15:0] bar_tab [16];

    n_checks = 0;
    n_errors = 0;
    nRST = 1'b1; en = 1'b0; mode = 2'd0; solid_rgb = 16'h0000;
    model_reset();
    for (int i = 0; i < 16; i++) bar_tab[i] = bar_colour(i / 2);

    #2 nRST = 1'b0;
    #1 check_outputs();
    repeat (3) step();
    @(negedge PixelClk);
    nRST = 1'b1;
    step();

    // Steady raster, bars: frame period and per-frame sync/DE occupancy
    en = 1'b1; mode = 2'd0; solid_rgb = 16'(($urandom));
    de_cnt = 0; hs_low = 0; vs_low = 0; de_first = -1;
    for (int c = 0; c < 2 * FT + 3; c++) begin
      step();
      if (fs_a) fs_idx.push_back(c);
      if (fs_idx.size() == 1) begin
        if (de_a) de_cnt++;
        if (!hs_a) hs_low++;
        if (!vs_a) vs_low++;
      end
      if (de_a && de_first < 0) begin
        de_first = c;
        check("de_rise_px", 32'(px_a), 32'd0);
      end
      if (de_a && py_a == '0) check("bar_line0", 32'({r_a, g_a, b_a}), 32'(bar_tab[px_a[3:0]]));
    end
    check("fs_pulses", 32'(fs_idx.size()), 32'd3);
    if (fs_idx.size() >= 2) begin
      check("first_fs", 32'(fs_idx[0]), 32'd0);
      check("fs_period", 32'(fs_idx[1] - fs_idx[0]), 32'd161);
    end
    check("de_per_frame", 32'(de_cnt), 32'd64);
    check("hs_low_per_frame", 32'(hs_low), 32'd14);
    check("vs_low_per_frame", 32'(vs_low), 32'd23);
    check("de_rise_cycle", 32'(de_first), 32'd51);

    // Mode switch mid-frame takes effect only from the next frame
    repeat (80) step();
    mode = 2'd2; solid_rgb = 16'hF800;
    for (guard = 0; guard < FT && !fs_a; guard++) step();
    check("wait_fs", 32'(fs_a), 32'd1);
    solid_cnt = 0; off_de_rgb = 0;
    for (int c = 0; c < FT - 1; c++) begin
      step();
      if (de_a && {r_a, g_a, b_a} == 16'hF800) solid_cnt++;
      if (!de_a && {r_a, g_a, b_a} != 16'h0000) off_de_rgb++;
    end
    check("solid_px", 32'(solid_cnt), 32'd64);
    check("rgb_off_de", 32'(off_de_rgb), 32'd0);

    // Enable drop at h=10, v=3 then restart from the origin
    for (guard = 0; guard < 2 * FT && pos != 3 * HT + 10; guard++) step();
    check("reach_h10_v3", 32'(pos), 32'(3 * HT + 10));
    en = 1'b0;
    step();
    check("en_off_de", 32'({de_a, fs_a, ls_a}), 32'd0);
    check("en_off_hs", 32'(hs_a), 32'd1);
    repeat (5) step();
    en = 1'b1;
    step();
    check("restart_fs", 32'(fs_a), 32'd1);
    check("restart_hs", 32'(hs_a), 32'd0);

    // Randomised run: enable gaps, pattern changes, per-cycle solid colour
    for (int c = 0; c < 1500; c++) begin
      if (en) begin
        if ($urandom_range(0, 99) < 2) en = 1'b0;
      end else if ($urandom_range(0, 99) < 30) begin
        en = 1'b1;
      end
      if ($urandom_range(0, 99) < 1) mode = 2'($urandom_range(0, 3));
      solid_rgb = 16'($urandom);
      step();
    end

    // Asynchronous reset while pixels are active
    en = 1'b1; mode = 2'd3;
    for (guard = 0; guard < 2 * FT && !e_de; guard++) step();
    check("reach_active", 32'(de_a), 32'd1);
    do_reset();
    mode = 2'd1;
    for (int c = 0; c < 2 * FT; c++) begin
      solid_rgb = 16'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
Parametrised RGB565 parallel-LCD timing and test-pattern generator, the next generation of the fixed 800x480 bar generator.
- Generates HSYNC/VSYNC/DE from per-port timing parameters, with configurable sync polarity.
- Exposes active-pixel coordinates and frame/line strobes so downstream pixel sources can align to the raster.
- Provides four runtime-selectable test patterns, latched per frame; sits directly in front of the LCD pins.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 210, horizontal front porch (pixels)
H_SYNC, 1, HSYNC pulse width (pixels, >=1)
H_BP, 182, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 45, vertical front porch (lines)
V_SYNC, 5, VSYNC pulse width (lines, >=1)
V_BP, 1, vertical back porch (lines)
HS_POL, 0, HSYNC active level (0 = active-low)
VS_POL, 0, VSYNC active level (0 = active-low)
CW, 12, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
PixelClk  in  1  pixel clock
nRST  in  1  asynchronous active-low reset
en  in  1  run enable; 0 holds the raster at origin
mode  in  2  pattern select: 0 bars, 1 grid, 2 solid, 3 gradient
solid_rgb  in  16  RGB565 colour for mode 2
LCD_DE  out  1  data enable
LCD_HSYNC  out  1  horizontal sync
LCD_VSYNC  out  1  vertical sync
LCD_R  out  5  red
LCD_G  out  6  green
LCD_B  out  5  blue
pix_x  out  CW  active column, valid when LCD_DE=1
pix_y  out  CW  active row, valid when LCD_DE=1
frame_start  out  1  one-cycle pulse at h=0, v=0
line_start  out  1  one-cycle pulse at h=0 of every line

Behaviour:
- Reset is nRST, asynchronous, active-low; clock is PixelClk.
- Derived: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise. Line order is sync, back porch, active, front porch.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments only on the h wrap, and wraps 0 after V_TOTAL-1.
- en=0: h_cnt and v_cnt are cleared to 0 synchronously. All outputs go to their reset values on the next edge.
- After en rises, the first counted cycle is h=0, v=0, which produces frame_start.
- Sync/enable decode:
  - HSYNC is active while h_cnt < H_SYNC.
  - VSYNC is active while v_cnt < V_SYNC.
  - DE=1 iff h_cnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) AND v_cnt is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- pix_x = h_cnt-(H_SYNC+H_BP) and pix_y = v_cnt-(V_SYNC+V_BP) when DE=1; both outputs are 0 when DE=0.
- Latency: all outputs are registered. The output at edge n+1 reflects the counters at edge n, so every output has identical 1-cycle latency and sync/DE/RGB stay aligned.
- Reset values: DE=0, RGB=0, pix_x=pix_y=0, frame_start=line_start=0, HSYNC=~HS_POL, VSYNC=~VS_POL. Reset mid-frame restarts at the origin.
- Mode latching: mode is sampled into mode_q only on the frame_start cycle, so a frame never mixes patterns. mode_q resets to 0.
- RGB is 0 whenever DE=0. When DE=1 the colour depends on mode_q:
  - 0 (bars): 8 equal bars with boundaries k*H_ACTIVE/8 (elaboration constants, no divider). Colour order: white, yellow, cyan, green, magenta, red, blue, black. Any remainder pixels are black.
  - 1 (grid): white where pix_x[4:0]==0 or pix_y[4:0]==0, else black.
  - 2 (solid): solid_rgb[15:11]/[10:5]/[4:0], with solid_rgb sampled each cycle.
  - 3 (gradient): R=pix_x[7:3], G=pix_y[7:2], B=~pix_x[7:3].
- Strobes: frame_start and line_start may coincide, and both are asserted at h=0, v=0.

Optional Feature:
LCD_TIMING_FRAME_CNT_EN
- Defined: adds output port frame_cnt (16 bits). It increments on each frame_start, wraps at 0xFFFF, and resets to 0.
- Also in mode 0 only, the bar index becomes (bar + frame_cnt[9:6]) mod 8, so the bars scroll one position every 64 frames.
- Undefined: the port and counter are absent, and the bars are static.

Decomposition:
- Package lcd_timing_pkg holds:
  - mode encodings MODE_BARS/MODE_GRID/MODE_SOLID/MODE_GRAD;
  - the 8-entry RGB565 bar colour constant array;
  - the white and black constants.
- One sub-module, lcd_pattern_rgb: combinational pattern generator from (mode_q, pix_x, pix_y, solid_rgb, scroll) to RGB565. Its result is registered in the parent.

Test Plan:
Bench parameters unless stated otherwise: H_ACTIVE=16, H_SYNC=2, H_BP=3, H_FP=2 (H_TOTAL=23); V_ACTIVE=4, V_SYNC=1, V_BP=1, V_FP=1 (V_TOTAL=7).
- Reset, then en=1 -> frame_start pulses every 161 cycles. HSYNC is low for 2 cycles per 23. VSYNC is low for 23 cycles per frame. DE is high for exactly 64 cycles per frame.
- Mode 0 -> on the first active line, pixels 0-1 are 0xFFFF, pixels 2-3 are 0xFFE0, ..., pixels 14-15 are 0x0000. LCD_DE rises 1 cycle after h_cnt=5, and pix_x=0 is in the same cycle.
- Mode changes from 0 to 2 mid-frame (solid_rgb=0xF800) -> the current frame stays bars. The next frame is all 0xF800 during DE, and RGB=0 outside DE.
- HS_POL=1, VS_POL=1 -> sync outputs invert, and both are 0 during reset.
- en drops at h=10, v=3 -> all outputs go inactive next cycle. When en rises, the counters restart at 0,0 and frame_start pulses on the first output cycle.
- Reset asserted mid-active -> outputs go to reset values immediately and asynchronously, and mode_q returns to bars.
